// File: rtl/wb_bus_arbiter_if.sv
// Write-back result bus bundle shared by the arbiter (master) and the
// tristate source registers / destination register (slave).
interface wb_bus_arbiter_if #(
  parameter int NrOfSources = 4,
  parameter int IdWidth     = 2
);
  logic                   Tick;
  logic [NrOfSources-1:0] Req;
  logic [NrOfSources-1:0] Cs;
  logic [NrOfSources-1:0] Grant;
  logic                   Capture;
  logic [IdWidth-1:0]     GrantId;
  logic                   Busy;

  modport master (
    input  Tick, Req,
    output Cs, Grant, Capture, GrantId, Busy
  );

  modport slave (
    output Tick, Req,
    input  Cs, Grant, Capture, GrantId, Busy
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin drive/capture arbiter for the shared write-back bus.
// Define WB_TURNAROUND_EN to insert a dead TURN cycle between two drivers.
module wb_bus_arbiter #(
  parameter int NrOfSources = 4,
  parameter int IdWidth     = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  wb_bus_arbiter_if.master bus
);

  if (NrOfSources < 2 || NrOfSources > 8) begin : g_bad_n
    $error("wb_bus_arbiter: NrOfSources must be 2..8");
  end
  if (IdWidth < $clog2(NrOfSources)) begin : g_bad_id
    $error("wb_bus_arbiter: IdWidth too small for NrOfSources");
  end

`ifdef WB_TURNAROUND_EN
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, TURN} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;
`endif

  state_t                 state_q, state_d;
  logic [IdWidth-1:0]     owner_q, owner_d;
  logic [IdWidth-1:0]     ptr_q, ptr_d;
  logic [NrOfSources-1:0] masked;
  logic [IdWidth:0]       pick_idle, pick_next;

  // Returns {found, index}: the set bit closest above ptr, wrapping with an
  // explicit distance compare so non-power-of-two counts wrap correctly.
  function automatic logic [IdWidth:0] rr_pick(
    input logic [NrOfSources-1:0] req,
    input logic [IdWidth-1:0]     ptr
  );
    logic               found;
    logic [IdWidth-1:0] idx;
    int                 best;
    int                 d;
    found = 1'b0;
    idx   = '0;
    best  = NrOfSources + 1;
    for (int k = 0; k < NrOfSources; k++) begin
      d = k - int'(ptr);
      if (d <= 0) d = d + NrOfSources;
      if (req[k] && d < best) begin
        best  = d;
        idx   = IdWidth'(k);
        found = 1'b1;
      end
    end
    return {found, idx};
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= IdWidth'(NrOfSources - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    masked    = bus.Req;
    masked[owner_q] = 1'b0;
    pick_idle = rr_pick(bus.Req, ptr_q);
    pick_next = rr_pick(masked, owner_q);
    if (bus.Tick) begin
      case (state_q)
        IDLE: begin
          if (pick_idle[IdWidth]) begin
            owner_d = pick_idle[IdWidth-1:0];
            state_d = DRIVE;
          end
        end
        DRIVE: begin
          state_d = bus.Req[owner_q] ? CAPTURE : IDLE;
        end
        CAPTURE: begin
          // The finishing owner still holds Req this cycle, hence the mask.
          ptr_d = owner_q;
          if (pick_next[IdWidth]) begin
            owner_d = pick_next[IdWidth-1:0];
`ifdef WB_TURNAROUND_EN
            state_d = TURN;
`else
            state_d = DRIVE;
`endif
          end else begin
            state_d = IDLE;
          end
        end
`ifdef WB_TURNAROUND_EN
        TURN: begin
          state_d = DRIVE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Cs      = '1;
    bus.Grant   = '0;
    bus.Capture = 1'b0;
    bus.Busy    = 1'b0;
    bus.GrantId = owner_q;
    case (state_q)
      DRIVE: begin
        bus.Cs[owner_q] = 1'b0;
        bus.Busy        = 1'b1;
      end
      CAPTURE: begin
        bus.Cs[owner_q]    = 1'b0;
        bus.Grant[owner_q] = 1'b1;
        bus.Capture        = 1'b1;
        bus.Busy           = 1'b1;
      end
`ifdef WB_TURNAROUND_EN
      TURN: begin
        bus.Busy = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  a_single_driver: assert property (@(posedge Clock) disable iff (Reset)
    $countones(~bus.Cs) <= 1);
  a_grant_onehot: assert property (@(posedge Clock) disable iff (Reset)
    $onehot0(bus.Grant) && ((|bus.Grant) == bus.Capture));
  a_grantid_match: assert property (@(posedge Clock) disable iff (Reset)
    (state_q == DRIVE || state_q == CAPTURE) |-> !bus.Cs[bus.GrantId]);
`endif

endmodule
